// File: rtl/iddr_gearbox.sv
// IDDRX1F 1:2 pair stream to 8-bit word gearbox.
// Bit-slip alignment, manual or automatic comma hunt.
module iddr_gearbox #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter string      AUTO_ALIGN = "ENABLED"
) (
    input  logic       SCLK,
    input  logic       RST,
    input  logic       Q0,
    input  logic       Q1,
    input  logic       BITSLIP,
    input  logic       ALIGN_REQ,
    output logic [7:0] DOUT,
    output logic       DVALID,
    output logic       LOCKED,
    output logic       ALIGN_FAIL
);

    localparam bit AUTO = (AUTO_ALIGN == "ENABLED");

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SETTLE = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  sr_q, sr_d;
    logic        off_q, off_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  slipcnt_q, slipcnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        dvalid_q, dvalid_d;
    logic        fail_q, fail_d;
    logic        auto_slip;
    logic        slip;
    logic        stall;

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            off_q     <= 1'b0;
            cnt_q     <= '0;
            slipcnt_q <= '0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            slipcnt_q <= slipcnt_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            fail_q    <= fail_d;
        end
    end

    // ALIGN_REQ outranks everything, including a same-edge comma match
    always_comb begin
        state_d   = state_q;
        slipcnt_d = slipcnt_q;
        fail_d    = fail_q;
        auto_slip = 1'b0;
        if (AUTO) begin
            if (ALIGN_REQ) begin
                state_d   = HUNT;
                slipcnt_d = '0;
                fail_d    = 1'b0;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        if (dvalid_q) begin
                            if (dout_q == COMMA) begin
                                state_d = LOCK;
                            end else begin
                                auto_slip = 1'b1;
                                slipcnt_d = slipcnt_q + 3'd1;
                                if (slipcnt_q == 3'd7) begin
                                    fail_d = 1'b1;
                                end
                                state_d = SETTLE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (dvalid_q) begin
                            state_d = HUNT;
                        end
                    end
                    LOCK: begin
                        state_d = LOCK;
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end
    end

    // Slip from OFF=0 stalls one edge and narrows the window by one bit:
    // net effect is always one bit later in time.
    always_comb begin
        slip     = AUTO ? auto_slip : BITSLIP;
        stall    = slip & ~off_q;
        sr_d     = 10'({sr_q, Q0, Q1});
        off_d    = slip ? ~off_q : off_q;
        cnt_d    = stall ? cnt_q : cnt_q + 2'd1;
        dvalid_d = ~stall & (cnt_q == 2'd3);
        dout_d   = dout_q;
        if (dvalid_d) begin
            dout_d = off_q ? sr_d[8:1] : sr_d[7:0];
        end
    end

    always_comb begin
        DOUT       = dout_q;
        DVALID     = dvalid_q;
        LOCKED     = AUTO && (state_q == LOCK);
        ALIGN_FAIL = AUTO && fail_q;
    end

endmodule

// File: tb/tb_iddr_gearbox.sv
// Directed bench for iddr_gearbox: manual slip instance and
// auto-align instance sharing one serial stream.
module tb_iddr_gearbox;

    logic       clk;
    logic       rst_n;
    logic       q0, q1;
    logic       bitslip;
    logic       align_req;

    logic [7:0] a_dout, m_dout;
    logic       a_dv, m_dv;
    logic       a_locked, m_locked;
    logic       a_fail, m_fail;

    logic [7:0] pat;
    int         pos;
    int         nvec;
    int         nmis;

    iddr_gearbox #(
        .COMMA      (8'hBC),
        .AUTO_ALIGN ("ENABLED")
    ) u_auto (
        .SCLK       (clk),
        .RST        (rst_n),
        .Q0         (q0),
        .Q1         (q1),
        .BITSLIP    (bitslip),
        .ALIGN_REQ  (align_req),
        .DOUT       (a_dout),
        .DVALID     (a_dv),
        .LOCKED     (a_locked),
        .ALIGN_FAIL (a_fail)
    );

    iddr_gearbox #(
        .COMMA      (8'hBC),
        .AUTO_ALIGN ("DISABLED")
    ) u_man (
        .SCLK       (clk),
        .RST        (rst_n),
        .Q0         (q0),
        .Q1         (q1),
        .BITSLIP    (bitslip),
        .ALIGN_REQ  (align_req),
        .DOUT       (m_dout),
        .DVALID     (m_dv),
        .LOCKED     (m_locked),
        .ALIGN_FAIL (m_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        int s;
        s = k % 8;
        if (s == 0) return v;
        return (v << s) | (v >> (8 - s));
    endfunction

    // One edge: present the next pair, sample 1 ns after the edge.
    task automatic step();
        q0 = pat[7 - (pos % 8)];
        q1 = pat[7 - ((pos + 1) % 8)];
        @(posedge clk);
        #1;
        pos += 2;
        bitslip   = 1'b0;
        align_req = 1'b0;
    endtask

    task automatic wait_word(input string tag, input logic [7:0] exp,
                             input bit man, output int n);
        logic dv;
        n  = 0;
        dv = 1'b0;
        while (!dv && n < 40) begin
            step();
            n++;
            dv = man ? m_dv : a_dv;
        end
        if (!dv) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk(tag, man ? m_dout : a_dout, exp);
        end
    endtask

    task automatic hunt(input int budget, input bit for_fail,
                        output int words);
        int  n;
        logic hit;
        words = 0;
        n     = 0;
        hit   = 1'b0;
        while (!hit && n < budget) begin
            step();
            n++;
            if (a_dv) words++;
            hit = for_fail ? a_fail : a_locked;
        end
    endtask

    initial begin
        int n;
        int words;
        nvec      = 0;
        nmis      = 0;
        pat       = 8'hA5;
        pos       = 0;
        q0        = 1'b0;
        q1        = 1'b0;
        bitslip   = 1'b0;
        align_req = 1'b0;
        rst_n     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_dout", m_dout, 8'h00);
        chk("rst_m_dv", m_dv, 1'b0);
        chk("rst_a_locked", a_locked, 1'b0);
        chk("rst_a_fail", a_fail, 1'b0);
        rst_n = 1'b1;
        pos   = 0;

        for (int e = 1; e <= 12; e++) begin
            step();
            chk("aligned_dv", m_dv, 32'(e % 4 == 0));
            if (e % 4 == 0) chk("aligned_dout", m_dout, 8'hA5);
        end

        bitslip = 1'b1;
        step();
        chk("stall_dv", m_dv, 1'b0);
        wait_word("slip1", 8'h4B, 1'b1, n);
        chk("slip1_lat", n, 4);

        repeat (3) step();
        bitslip = 1'b1;
        step();
        chk("preoff_dv", m_dv, 1'b1);
        chk("preoff_dout", m_dout, 8'h4B);
        wait_word("slip2", 8'h96, 1'b1, n);
        chk("slip2_lat", n, 4);

        for (int k = 3; k <= 8; k++) begin
            bitslip = 1'b1;
            step();
            wait_word("slipk", rotl(8'hA5, k), 1'b1, n);
            chk("slipk_lat", n, (k % 2 == 1) ? 4 : 3);
        end
        chk("slip8_dout", m_dout, 8'hA5);
        chk("man_locked", m_locked, 1'b0);
        chk("man_fail", m_fail, 1'b0);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pat   = 8'hBC;
        pos   = 5;
        hunt(120, 1'b0, words);
        chk("lock1", a_locked, 1'b1);
        chk("lock1_words", words, 7);
        chk("lock1_dout", a_dout, 8'hBC);
        chk("lock1_fail", a_fail, 1'b0);
        wait_word("locked_word", 8'hBC, 1'b0, n);

        align_req = 1'b1;
        step();
        chk("req_unlock", a_locked, 1'b0);
        wait_word("hunt_word", 8'hBC, 1'b0, n);
        align_req = 1'b1;
        step();
        chk("req_prio", a_locked, 1'b0);
        wait_word("relock_word", 8'hBC, 1'b0, n);
        step();
        chk("relock", a_locked, 1'b1);

        pos += 1;
        align_req = 1'b1;
        step();
        chk("shift_unlock", a_locked, 1'b0);
        hunt(200, 1'b0, words);
        chk("lock2", a_locked, 1'b1);
        chk("lock2_words", words, 15);
        chk("lock2_dout", a_dout, 8'hBC);
        chk("lock2_fail", a_fail, 1'b0);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pat   = 8'h00;
        pos   = 0;
        hunt(200, 1'b1, words);
        chk("fail_set", a_fail, 1'b1);
        chk("fail_words", words, 15);
        chk("fail_locked", a_locked, 1'b0);
        align_req = 1'b1;
        step();
        chk("fail_clr", a_fail, 1'b0);

        pat = 8'hBC;
        hunt(200, 1'b0, words);
        chk("lock3", a_locked, 1'b1);
        wait_word("lock3_word", 8'hBC, 1'b0, n);
        step();
        step();
        chk("pre_rst_dout", a_dout, 8'hBC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", a_dout, 8'h00);
        chk("arst_dv", a_dv, 1'b0);
        chk("arst_locked", a_locked, 1'b0);
        chk("arst_fail", a_fail, 1'b0);
        #1;
        rst_n = 1'b1;
        pos   = 0;
        n     = 0;
        do begin
            step();
            n++;
        end while (!a_dv && n < 10);
        chk("arst_first_dv", n, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
